// File: rtl/gtrg_readout_seq.sv
// gtrg_readout_seq: pops the DAV/BX FIFO head, then emits the event header, requests each flagged source in turn and closes the event with a trailer.
module gtrg_readout_seq #(
    parameter int TMO_CYCLES = 1023,
    parameter int GAP_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EMPTY_B,
    input  logic [16:0] DAVSOUT,
    input  logic [11:0] BXCOUNTOUT,
    input  logic [3:0]  CFEBBX,
    output logic        POP,
    output logic [15:0] HDR_DATA,
    output logic        HDR_VALID,
    input  logic        HDR_READY,
    output logic [6:0]  SRC_REQ,
    input  logic [6:0]  SRC_DONE,
    output logic        BUSY,
    output logic [11:0] EVT_CNT,
    output logic [6:0]  TMO_ERR
);
    typedef enum logic [2:0] {IDLE, SETTLE, LATCH, HDR, SRC, TRL, GAP} state_t;
    state_t state, nxt;
    logic [16:0] dav;
    logic [11:0] bx;
    logic [3:0]  cbx;
    logic [1:0]  hidx;
    logic [2:0]  k;
    logic [9:0]  wcnt;
    logic [2:0]  gcnt;
    logic [6:0]  tmo;
    logic [6:0]  src_dav;
    logic        want, done, tmo_hit, src_leave;
    // source order: ALCT, TMB, CFEB1..5
    assign src_dav   = {dav[5:1], dav[0], dav[16]};
    assign want      = src_dav[k];
    assign done      = SRC_DONE[k];
    assign tmo_hit   = want && !done && wcnt == 10'(TMO_CYCLES - 1);
    assign src_leave = !want || done || tmo_hit;
    always_ff @(posedge CLK) begin
        state <= RST ? IDLE : nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (EMPTY_B) nxt = SETTLE;
            SETTLE:  nxt = LATCH;
            LATCH:   nxt = EMPTY_B ? HDR : IDLE;
            HDR:     if (HDR_READY && hidx == 2'd3) nxt = SRC;
            SRC:     if (src_leave && k == 3'd6) nxt = TRL;
            TRL:     if (HDR_READY) nxt = GAP;
            GAP:     if (gcnt == 3'(GAP_CYCLES - 1)) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            dav     <= '0;
            bx      <= '0;
            cbx     <= '0;
            hidx    <= '0;
            k       <= '0;
            wcnt    <= '0;
            gcnt    <= '0;
            tmo     <= '0;
            TMO_ERR <= '0;
            EVT_CNT <= '0;
        end else begin
            if (state == LATCH) {dav, bx, cbx, tmo} <= {DAVSOUT, BXCOUNTOUT, CFEBBX, 7'd0};
            hidx <= (state == HDR) ? hidx + 2'(HDR_READY) : 2'd0;
            k    <= (state == SRC) ? k + 3'(src_leave) : 3'd0;
            wcnt <= (state == SRC && !src_leave) ? wcnt + 10'd1 : 10'd0;
            gcnt <= (state == GAP) ? gcnt + 3'd1 : 3'd0;
            if (state == SRC && tmo_hit) begin
                tmo[k]     <= 1'b1;
                TMO_ERR[k] <= 1'b1;
            end
            if (state == TRL && HDR_READY) EVT_CNT <= EVT_CNT + 12'd1;
        end
    end
    always_comb begin
        POP       = state == LATCH && EMPTY_B;
        HDR_VALID = state == HDR || state == TRL;
        HDR_DATA  = state == TRL ? {4'hE, 5'b0, tmo} :
                    state != HDR ? 16'd0 :
                    hidx == 2'd0 ? {4'h9, bx} :
                    hidx == 2'd1 ? {4'hA, cbx, 1'b0, dav[16], dav[0], dav[5:1]} :
                    hidx == 2'd2 ? {4'hB, 2'b00, dav[10:6], dav[15:11]} :
                                   {4'hC, EVT_CNT};
        SRC_REQ   = (state == SRC && want) ? 7'b1 << k : 7'd0;
        BUSY      = state != IDLE;
    end
endmodule

// File: tb/tb_gtrg_readout_seq.sv
// tb_gtrg_readout_seq: directed scenarios against a small FIFO model and a DONE responder.
module tb_gtrg_readout_seq;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        HDR_READY = 1'b0;
    logic        EMPTY_B, POP, HDR_VALID, BUSY;
    logic [16:0] DAVSOUT;
    logic [11:0] BXCOUNTOUT, EVT_CNT;
    logic [3:0]  CFEBBX;
    logic [15:0] HDR_DATA;
    logic [6:0]  SRC_REQ, SRC_DONE, TMO_ERR;
    int n_chk = 0, n_fail = 0;
    logic [32:0] fmem [0:7];
    int wr = 0, rd = 0;
    logic auto_mode = 1'b0, resp = 1'b0;
    logic [6:0] done_r = 7'd0, prev_req = 7'd0;
    logic [15:0] words [0:63];
    logic [6:0]  reqs [0:63];
    int pop_t [0:63];
    int nw = 0, npop = 0, nr = 0, ntrl = 0, cyc = 0;

    gtrg_readout_seq dut (
        .CLK(CLK), .RST(RST), .EMPTY_B(EMPTY_B), .DAVSOUT(DAVSOUT), .BXCOUNTOUT(BXCOUNTOUT),
        .CFEBBX(CFEBBX), .POP(POP), .HDR_DATA(HDR_DATA), .HDR_VALID(HDR_VALID), .HDR_READY(HDR_READY),
        .SRC_REQ(SRC_REQ), .SRC_DONE(SRC_DONE), .BUSY(BUSY), .EVT_CNT(EVT_CNT), .TMO_ERR(TMO_ERR)
    );

    always #5 CLK = ~CLK;
    // auto_mode presents an endless stream of empty-DAV entries
    assign EMPTY_B = auto_mode || (wr != rd);
    assign {DAVSOUT, BXCOUNTOUT, CFEBBX} = auto_mode ? 33'd0 : fmem[rd % 8];
    assign SRC_DONE = resp ? (done_r & SRC_REQ) : 7'd0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        done_r <= SRC_REQ;
        prev_req <= SRC_REQ;
        if (POP && !auto_mode && wr != rd) rd <= rd + 1;
        if (HDR_VALID && HDR_READY) begin
            words[nw % 64] <= HDR_DATA;
            nw <= nw + 1;
            if (HDR_DATA[15:12] == 4'hE) ntrl <= ntrl + 1;
        end
        if (POP) begin
            pop_t[npop % 64] <= cyc;
            npop <= npop + 1;
        end
        if (SRC_REQ != 7'd0 && SRC_REQ != prev_req) begin
            reqs[nr % 64] <= SRC_REQ;
            nr <= nr + 1;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push(input logic [16:0] d, input logic [11:0] b, input logic [3:0] c);
        fmem[wr % 8] = {d, b, c};
        wr = wr + 1;
    endtask

    task automatic wait_trl(input int target, input int lim);
        int t = 0;
        while (ntrl < target && t < lim) begin tick(); t++; end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (BUSY && t < 100) begin tick(); t++; end
    endtask

    task automatic test_reset();
        RST = 1'b1; tick(); tick();
        n_chk++; if (POP !== 1'b0) begin n_fail++; $display("FAIL reset_pop got=%b exp=0", POP); end
        n_chk++; if (HDR_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", HDR_VALID); end
        n_chk++; if (HDR_DATA !== 16'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", HDR_DATA); end
        n_chk++; if (SRC_REQ !== 7'd0) begin n_fail++; $display("FAIL reset_req got=%h exp=00", SRC_REQ); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        n_chk++; if (EVT_CNT !== 12'd0) begin n_fail++; $display("FAIL reset_evt got=%h exp=000", EVT_CNT); end
        n_chk++; if (TMO_ERR !== 7'd0) begin n_fail++; $display("FAIL reset_tmo got=%h exp=00", TMO_ERR); end
        RST = 1'b0; tick(); tick(); tick();
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_empty_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_single();
        int bw = nw, bp = npop, br = nr, bt = ntrl;
        logic [15:0] ew [0:4];
        logic [6:0] er [0:2];
        ew = '{16'h9123, 16'hA561, 16'hB000, 16'hC000, 16'hE000};
        er = '{7'h01, 7'h02, 7'h04};
        resp = 1'b1; HDR_READY = 1'b1;
        push(17'h10003, 12'h123, 4'h5);
        wait_trl(bt + 1, 300);
        n_chk++; if (ntrl !== bt + 1) begin n_fail++; $display("FAIL single_trailer_count got=%0d exp=%0d", ntrl - bt, 1); end
        n_chk++; if (npop - bp !== 1) begin n_fail++; $display("FAIL single_pop_count got=%0d exp=1", npop - bp); end
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (words[(bw + i) % 64] !== ew[i]) begin n_fail++; $display("FAIL single_word%0d got=%h exp=%h", i, words[(bw + i) % 64], ew[i]); end
        end
        n_chk++; if (nr - br !== 3) begin n_fail++; $display("FAIL single_req_count got=%0d exp=3", nr - br); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (reqs[(br + i) % 64] !== er[i]) begin n_fail++; $display("FAIL single_req%0d got=%h exp=%h", i, reqs[(br + i) % 64], er[i]); end
        end
        n_chk++; if (EVT_CNT !== 12'd1) begin n_fail++; $display("FAIL single_evt got=%0d exp=1", EVT_CNT); end
        wait_idle();
    endtask

    task automatic test_timeout();
        int bw = nw, bt = ntrl, t = 0, n = 0;
        resp = 1'b0; HDR_READY = 1'b1;
        push(17'h00004, 12'h010, 4'h0);
        while (!SRC_REQ[3] && t < 100) begin tick(); t++; end
        n_chk++; if (SRC_REQ !== 7'h08) begin n_fail++; $display("FAIL tmo_req got=%h exp=08", SRC_REQ); end
        while (SRC_REQ[3] && n < 2000) begin n++; tick(); end
        n_chk++; if (n !== 1023) begin n_fail++; $display("FAIL tmo_req_cycles got=%0d exp=1023", n); end
        wait_trl(bt + 1, 50);
        n_chk++; if (words[(bw + 4) % 64] !== 16'hE008) begin n_fail++; $display("FAIL tmo_trailer got=%h exp=e008", words[(bw + 4) % 64]); end
        n_chk++; if (TMO_ERR !== 7'h08) begin n_fail++; $display("FAIL tmo_err got=%h exp=08", TMO_ERR); end
        n_chk++; if (EVT_CNT !== 12'd2) begin n_fail++; $display("FAIL tmo_evt got=%0d exp=2", EVT_CNT); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int bw = nw, bp = npop, bt = ntrl, t = 0;
        resp = 1'b1; HDR_READY = 1'b0;
        push(17'h00000, 12'h456, 4'h3);
        while (!HDR_VALID && t < 20) begin tick(); t++; end
        n_chk++; if (HDR_DATA !== 16'h9456) begin n_fail++; $display("FAIL bp_h0 got=%h exp=9456", HDR_DATA); end
        HDR_READY = 1'b1; tick(); HDR_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if ({HDR_VALID, HDR_DATA} !== {1'b1, 16'hA300}) begin n_fail++; $display("FAIL bp_hold%0d got=%b/%h exp=1/a300", i, HDR_VALID, HDR_DATA); end
            tick();
        end
        HDR_READY = 1'b1; tick();
        n_chk++; if (HDR_DATA !== 16'hB000) begin n_fail++; $display("FAIL bp_h2 got=%h exp=b000", HDR_DATA); end
        n_chk++; if (npop - bp !== 1) begin n_fail++; $display("FAIL bp_pop_count got=%0d exp=1", npop - bp); end
        wait_trl(bt + 1, 100);
        n_chk++; if (words[(bw + 3) % 64] !== 16'hC002) begin n_fail++; $display("FAIL bp_h3 got=%h exp=c002", words[(bw + 3) % 64]); end
        n_chk++; if (TMO_ERR !== 7'h08) begin n_fail++; $display("FAIL bp_tmo_sticky got=%h exp=08", TMO_ERR); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int bw, bp, bt;
        logic [15:0] eh [0:2];
        eh = '{16'h9111, 16'h9222, 16'h9333};
        RST = 1'b1; tick(); RST = 1'b0;
        bw = nw; bp = npop; bt = ntrl;
        resp = 1'b1; HDR_READY = 1'b1;
        push(17'h0, 12'h111, 4'h1); push(17'h0, 12'h222, 4'h2); push(17'h0, 12'h333, 4'h3);
        wait_trl(bt + 3, 600);
        n_chk++; if (npop - bp !== 3) begin n_fail++; $display("FAIL b2b_pop_count got=%0d exp=3", npop - bp); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (words[(bw + 5 * i) % 64] !== eh[i]) begin n_fail++; $display("FAIL b2b_h0_%0d got=%h exp=%h", i, words[(bw + 5 * i) % 64], eh[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (pop_t[(bp + i + 1) % 64] - pop_t[(bp + i) % 64] < 4) begin n_fail++; $display("FAIL b2b_pop_gap%0d got=%0d exp>=4", i, pop_t[(bp + i + 1) % 64] - pop_t[(bp + i) % 64]); end
        end
        n_chk++; if (EVT_CNT !== 12'd3) begin n_fail++; $display("FAIL b2b_evt got=%0d exp=3", EVT_CNT); end
        n_chk++; if (TMO_ERR !== 7'd0) begin n_fail++; $display("FAIL b2b_tmo_cleared got=%h exp=00", TMO_ERR); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int bp = npop, bt = ntrl, t = 0;
        resp = 1'b1; HDR_READY = 1'b1;
        push(17'h10001, 12'hABC, 4'h0);
        while (SRC_REQ !== 7'h02 && t < 100) begin tick(); t++; end
        n_chk++; if (SRC_REQ !== 7'h02) begin n_fail++; $display("FAIL mid_reach_src1 got=%h exp=02", SRC_REQ); end
        RST = 1'b1; tick();
        n_chk++; if ({POP, HDR_VALID, HDR_DATA, SRC_REQ, BUSY} !== 26'd0) begin n_fail++; $display("FAIL mid_outputs got=%b%b/%h/%h/%b exp=all0", POP, HDR_VALID, HDR_DATA, SRC_REQ, BUSY); end
        n_chk++; if (EVT_CNT !== 12'd0) begin n_fail++; $display("FAIL mid_evt got=%0d exp=0", EVT_CNT); end
        RST = 1'b0;
        repeat (40) tick();
        n_chk++; if (ntrl !== bt) begin n_fail++; $display("FAIL mid_no_trailer got=%0d exp=0", ntrl - bt); end
        n_chk++; if (npop - bp !== 1) begin n_fail++; $display("FAIL mid_pop_count got=%0d exp=1", npop - bp); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_wrap();
        int bw, bt = ntrl;
        HDR_READY = 1'b1; resp = 1'b0;
        auto_mode = 1'b1;
        wait_trl(bt + 4095, 80000);
        auto_mode = 1'b0;
        n_chk++; if (ntrl - bt !== 4095) begin n_fail++; $display("FAIL wrap_preset got=%0d exp=4095", ntrl - bt); end
        n_chk++; if (EVT_CNT !== 12'hFFF) begin n_fail++; $display("FAIL wrap_evt_fff got=%h exp=fff", EVT_CNT); end
        wait_idle();
        bw = nw; bt = ntrl;
        push(17'h0, 12'h777, 4'h0);
        wait_trl(bt + 1, 100);
        n_chk++; if (words[(bw + 3) % 64] !== 16'hCFFF) begin n_fail++; $display("FAIL wrap_h3 got=%h exp=cfff", words[(bw + 3) % 64]); end
        n_chk++; if (words[(bw + 4) % 64] !== 16'hE000) begin n_fail++; $display("FAIL wrap_trailer got=%h exp=e000", words[(bw + 4) % 64]); end
        n_chk++; if (EVT_CNT !== 12'd0) begin n_fail++; $display("FAIL wrap_evt got=%h exp=000", EVT_CNT); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gtrg_readout_seq.md
Name: gtrg_readout_seq

Overview:
Readout sequencer directly downstream of the global-trigger DAV/BX FIFO. When the FIFO is non-empty it captures the head entry (DAV word, DMB BX count, CFEB BX) and pops it. It then emits a 4-word event header, requests data from each source flagged in the DAV word in a fixed order, and closes the event with a trailer. It feeds the DMB output/DDU frame builder through a valid/ready handshake.

Parameters:
TMO_CYCLES, 1023, cycles a source request may stay unanswered before timeout (10-bit counter, range 1..1023)
GAP_CYCLES, 2, idle cycles after the trailer before the next FIFO check (range 1..7)

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
EMPTY_B  in  1  FIFO non-empty
DAVSOUT  in  17  FIFO head: [0] TMB DAV, [5:1] CFEB DAV, [10:6] CFEB MOVLP, [15:11] LCT 5-bx OR, [16] ALCT DAV
BXCOUNTOUT  in  12  FIFO head DMB BX count
CFEBBX  in  4  FIFO head CFEB BX
POP  out  1  one-cycle FIFO read strobe
HDR_DATA  out  16  header/trailer word
HDR_VALID  out  1  HDR_DATA valid
HDR_READY  in  1  downstream accepts word
SRC_REQ  out  7  one-hot source request: [0] ALCT, [1] TMB, [6:2] CFEB1..5
SRC_DONE  in  7  per-source completion pulse
BUSY  out  1  high in any state except IDLE
EVT_CNT  out  12  events completed, wraps 4095->0
TMO_ERR  out  7  sticky per-source timeout flags

Behaviour:
- Reset: synchronous, takes effect on the CLK edge where RST=1. POP=0, HDR_VALID=0, HDR_DATA=0, SRC_REQ=0, BUSY=0, EVT_CNT=0, TMO_ERR=0, state=IDLE. RST asserted mid-event aborts the event immediately. No POP is issued and the event is not counted.
- The FIFO output register updates one cycle after a write or after an address change. The sequencer never samples the head on the same cycle EMPTY_B rises, nor within 2 cycles after POP.
- States: IDLE -> SETTLE -> LATCH -> HDR(0..3) -> SRC(k=0..6) -> TRL -> GAP -> IDLE.
- IDLE: go to SETTLE when EMPTY_B=1.
- SETTLE: one cycle, no action.
- LATCH: one cycle. Capture DAVSOUT, BXCOUNTOUT and CFEBBX into internal registers. Assert POP for exactly this cycle. If EMPTY_B has dropped, return to IDLE with no POP.
- HDR words, each held with HDR_VALID=1 until a cycle with HDR_READY=1:
  - H0={4'h9,BX[11:0]}
  - H1={4'hA,CFEBBX[3:0],1'b0,dav[16],dav[0],dav[5:1]}
  - H2={4'hB,2'b00,dav[10:6],dav[15:11]}
  - H3={4'hC,EVT_CNT}
  - Valid drops for one cycle between words only if READY was low; back-to-back acceptance is allowed.
- SRC(k), order ALCT(dav[16]), TMB(dav[0]), CFEB1..5(dav[5:1]):
  - DAV bit clear: skip, costing 1 cycle.
  - DAV bit set: SRC_REQ[k]=1 from state entry. Leave on the first cycle with SRC_DONE[k]=1 (REQ deasserts on the next edge).
  - Or leave when the 10-bit wait counter reaches TMO_CYCLES. Then set TMO_ERR[k]=1 and set event flag tmo[k].
  - SRC_DONE bits for other sources are ignored. A DONE arriving in the same cycle as the timeout counts as DONE.
- TRL: word {4'hE,5'b0,tmo[6:0]}, same handshake. On acceptance, EVT_CNT increments by 1 (modulo 4096).
- GAP: GAP_CYCLES idle cycles with BUSY=1, then IDLE.
- TMO_ERR clears only on RST.

Test Plan:
- Single event: write DAVSOUT=17'h10003 (ALCT, TMB, CFEB1), BX=12'h123, CFEBBX=4'h5, HDR_READY=1, DONE one cycle after each REQ. Expect POP one pulse; H0=16'h9123; H1=16'hA561; H2=16'hB000; H3=16'hC000; REQ order [0],[1],[2]; trailer=16'hE000; EVT_CNT=1.
- Timeout: DAVSOUT=17'h00004 (CFEB2), never DONE. Expect SRC_REQ[3] high for TMO_CYCLES cycles, TMO_ERR=7'h08, trailer=16'hE008.
- Backpressure: HDR_READY low for 5 cycles on H1. Expect H1 held stable with VALID=1, no POP repeat, and H2 only after acceptance.
- Back-to-back: 3 FIFO entries with different BX values. Expect exactly 3 POPs, each at least 2+GAP cycles apart, headers in FIFO order, EVT_CNT=3.
- Reset mid-event: RST during SRC(1). Expect all outputs 0 next cycle, EVT_CNT=0, no trailer emitted.
- Wrap: preset 4095 events, run one more. Expect EVT_CNT=0 and H3 of that event=16'hCFFF.
